// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access sequencer: one load/store at a time, request/ready
// handshake with timeout, store lane replication and load right-justification.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err_align,
  output logic        err_timeout,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FIN
  } state_t;

  state_t state, state_nxt;

  logic             is_store_q;
  logic [1:0]       size_q;
  logic [1:0]       lane_q;
  logic [CNT_W-1:0] cnt;
  logic             err_align_q;
  logic             err_timeout_q;

  logic             misaligned;
  logic [3:0]       be_nxt;
  logic [31:0]      wdata_nxt;
  logic [31:0]      rdata_aligned;

  // Alignment check and store-side lane mapping work on the raw command inputs
  always_comb begin
    misaligned = 1'b0;
    be_nxt     = '0;
    wdata_nxt  = '0;
    case (size)
      2'b00: begin
        be_nxt    = 4'b0001 << addr[1:0];
        wdata_nxt = {4{wdata[7:0]}};
      end
      2'b01: begin
        misaligned = addr[0];
        be_nxt     = addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt  = {2{wdata[15:0]}};
      end
      2'b10: begin
        misaligned = (addr[1:0] != 2'b00);
        be_nxt     = '1;
        wdata_nxt  = wdata;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Load-side lane selection uses the latched size and low address bits
  always_comb begin
    rdata_aligned = '0;
    case (size_q)
      2'b00: begin
        case (lane_q)
          2'd0:    rdata_aligned = {24'h0, mem_rdata[7:0]};
          2'd1:    rdata_aligned = {24'h0, mem_rdata[15:8]};
          2'd2:    rdata_aligned = {24'h0, mem_rdata[23:16]};
          default: rdata_aligned = {24'h0, mem_rdata[31:24]};
        endcase
      end
      2'b01:   rdata_aligned = lane_q[1] ? {16'h0, mem_rdata[31:16]} : {16'h0, mem_rdata[15:0]};
      default: rdata_aligned = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = misaligned ? FIN : REQ;
      end
      REQ: begin
        if (mem_ready || (cnt == CNT_LAST)) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_store_q    <= 1'b0;
      size_q        <= '0;
      lane_q        <= '0;
      cnt           <= '0;
      err_align_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      load_data     <= '0;
      mem_addr      <= '0;
      mem_be        <= '0;
      mem_wdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            is_store_q <= is_store;
            size_q     <= size;
            lane_q     <= addr[1:0];
            if (misaligned) begin
              err_align_q <= 1'b1;
            end else begin
              cnt       <= '0;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= be_nxt;
              mem_wdata <= wdata_nxt;
            end
          end
        end
        REQ: begin
          // mem_ready wins over the timeout on the final allowed cycle
          if (mem_ready) begin
            if (!is_store_q) load_data <= rdata_aligned;
          end else if (cnt == CNT_LAST) begin
            err_timeout_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIN: begin
          err_align_q   <= 1'b0;
          err_timeout_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign done        = (state == FIN);
  assign err_align   = (state == FIN) && err_align_q;
  assign err_timeout = (state == FIN) && err_timeout_q;
  assign mem_req     = (state == REQ);
  assign mem_we      = (state == REQ) && is_store_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed commands push expected memory
// requests and completions; a negedge monitor pops and compares them.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [1:0]  size = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, err_align, err_timeout;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .size(size),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err_align(err_align),
    .err_timeout(err_timeout), .load_data(load_data), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          chk_wd;
    int          len;
  } req_t;

  typedef struct {
    bit          ea;
    bit          et;
    logic [31:0] ld;
    int          lat;
  } resp_t;

  req_t  req_q[$];
  resp_t resp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_req(input bit we, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input bit chk_wd, input int len);
    req_t r;
    r.we = we; r.a = a; r.be = be; r.wd = wd; r.chk_wd = chk_wd; r.len = len;
    req_q.push_back(r);
  endtask

  task automatic push_resp(input bit ea, input bit et, input logic [31:0] ld, input int lat);
    resp_t r;
    r.ea = ea; r.et = et; r.ld = ld; r.lat = lat;
    resp_q.push_back(r);
  endtask

  // Monitor
  int   cyc = 0;
  int   issue_cyc = 0;
  bit   req_prev = 1'b0;
  int   req_len = 0;
  req_t cur_req;

  always @(negedge clk) begin
    resp_t rs;
    cyc++;
    if (rst) begin
      req_prev = 1'b0;
      req_len  = 0;
    end else begin
      if (mem_req) begin
        if (!req_prev) begin
          if (req_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_req: mem_req=1 at addr %h, required no request", mem_addr);
            cur_req.len = -1;
          end else begin
            cur_req = req_q.pop_front();
            check("mem_we", 32'(mem_we), 32'(cur_req.we));
            check("mem_addr", mem_addr, cur_req.a);
            check("mem_be", 32'(mem_be), 32'(cur_req.be));
            if (cur_req.chk_wd) check("mem_wdata", mem_wdata, cur_req.wd);
          end
          req_len = 0;
        end
        req_len++;
      end else if (req_prev && cur_req.len >= 0) begin
        check("req_len", 32'(req_len), 32'(cur_req.len));
      end
      req_prev = mem_req;

      if (done) begin
        if (resp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: done=1, required 0");
        end else begin
          rs = resp_q.pop_front();
          check("err_align", 32'(err_align), 32'(rs.ea));
          check("err_timeout", 32'(err_timeout), 32'(rs.et));
          check("load_data", load_data, rs.ld);
          check("latency", 32'(cyc - issue_cyc), 32'(rs.lat));
        end
      end
      if (start && !busy) issue_cyc = cyc;
    end
  end

  task automatic run(input bit st, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input int waits);
    int n;
    @(posedge clk); #1;
    is_store = st; size = sz; addr = a; wdata = wd; mem_rdata = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (mem_req && n < 40) begin
      mem_ready = (n == waits);
      @(posedge clk); #1;
      mem_ready = 1'b0;
      n++;
    end
    if (n >= 40) begin
      total++; bad++;
      $display("FAIL req_bound: mem_req still high after %0d cycles, required release", n);
    end
    n = 0;
    while (busy && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 10) begin
      total++; bad++;
      $display("FAIL idle_bound: busy still high after %0d cycles, required idle", n);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_flags", {30'h0, err_align, err_timeout}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_be", 32'(mem_be), 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_load_data", load_data, 32'h0);
    rst = 1'b0;

    // mem_ready in IDLE must have no effect
    @(posedge clk); #1; mem_ready = 1'b1;
    @(posedge clk); #1; mem_ready = 1'b0;
    check("idle_ready_busy", 32'(busy), 32'h0);

    push_req(1'b0, 32'h0000_1000, 4'b1000, 32'h0, 1'b0, 1);
    push_resp(1'b0, 1'b0, 32'h0000_00AA, 2);
    run(1'b0, 2'b00, 32'h0000_1003, 32'h0, 32'hAABB_CCDD, 0);

    push_req(1'b1, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 1'b1, 4);
    push_resp(1'b0, 1'b0, 32'h0000_00AA, 5);
    run(1'b1, 2'b01, 32'h0000_2002, 32'h1234_BEEF, 32'h0, 3);

    push_resp(1'b1, 1'b0, 32'h0000_00AA, 1);
    run(1'b0, 2'b10, 32'h0000_3001, 32'h0, 32'h0, 0);
    push_resp(1'b1, 1'b0, 32'h0000_00AA, 1);
    run(1'b0, 2'b01, 32'h0000_3001, 32'h0, 32'h0, 0);
    push_resp(1'b1, 1'b0, 32'h0000_00AA, 1);
    run(1'b0, 2'b11, 32'h0000_3000, 32'h0, 32'h0, 0);

    push_req(1'b0, 32'h0000_4000, 4'b0001, 32'h0, 1'b0, 4);
    push_resp(1'b0, 1'b1, 32'h0000_00AA, 5);
    run(1'b0, 2'b00, 32'h0000_4000, 32'h0, 32'h5555_5555, -1);

    push_req(1'b0, 32'h0000_5000, 4'b1111, 32'h0, 1'b0, 2);
    push_resp(1'b0, 1'b0, 32'h1122_3344, 3);
    run(1'b0, 2'b10, 32'h0000_5000, 32'h0, 32'h1122_3344, 1);

    push_req(1'b0, 32'h0000_6000, 4'b1100, 32'h0, 1'b0, 1);
    push_resp(1'b0, 1'b0, 32'h0000_CAFE, 2);
    run(1'b0, 2'b01, 32'h0000_6002, 32'h0, 32'hCAFE_F00D, 0);

    push_req(1'b1, 32'h0000_7000, 4'b0010, 32'hA5A5_A5A5, 1'b1, 3);
    push_resp(1'b0, 1'b0, 32'h0000_CAFE, 4);
    run(1'b1, 2'b00, 32'h0000_7001, 32'h0000_00A5, 32'hFFFF_FFFF, 2);

    push_req(1'b1, 32'h0000_8000, 4'b1111, 32'hDEAD_BEEF, 1'b1, 1);
    push_resp(1'b0, 1'b0, 32'h0000_CAFE, 2);
    run(1'b1, 2'b10, 32'h0000_8000, 32'hDEAD_BEEF, 32'h0, 0);

    // start held high across an access; inputs switch to the second command mid-flight
    push_req(1'b1, 32'h0000_9000, 4'b1111, 32'h0102_0304, 1'b1, 1);
    push_resp(1'b0, 1'b0, 32'h0000_CAFE, 2);
    push_req(1'b0, 32'h0000_9000, 4'b0100, 32'h0, 1'b0, 1);
    push_resp(1'b0, 1'b0, 32'h0000_0077, 2);
    @(posedge clk); #1;
    is_store = 1'b1; size = 2'b10; addr = 32'h0000_9000; wdata = 32'h0102_0304; start = 1'b1;
    @(posedge clk); #1;
    is_store = 1'b0; size = 2'b00; addr = 32'h0000_9002; wdata = 32'h0;
    mem_rdata = 32'h0077_0000; mem_ready = 1'b1;
    @(posedge clk); #1; mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; start = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1; mem_ready = 1'b0;
    @(posedge clk); #1;
    check("cont_idle", 32'(busy), 32'h0);

    // reset during REQ abandons the access without a done pulse
    push_req(1'b0, 32'h0000_A000, 4'b1111, 32'h0, 1'b0, -1);
    @(posedge clk); #1;
    is_store = 1'b0; size = 2'b10; addr = 32'h0000_A000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("rstreq_mem_req", 32'(mem_req), 32'h0);
    check("rstreq_busy", 32'(busy), 32'h0);
    check("rstreq_load_data", load_data, 32'h0);
    repeat (5) @(posedge clk);
    #1;

    check("req_q_empty", 32'(req_q.size()), 32'h0);
    check("resp_q_empty", 32'(resp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Multi-cycle data-memory access sequencer for the CPU's MEM stage. It sits directly upstream of the load-data extension stage (byte/halfword sign/zero-extend).
- Accepts one load/store command at a time and handles the request/ready handshake with data memory, including timeout.
- Stores: generates the word-aligned address, byte enables and lane-replicated write data.
- Loads: right-justifies the addressed byte/halfword into bits [7:0]/[15:0] of load_data, which the extension stage consumes.

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles mem_req is held without mem_ready before the access is aborted (must be >= 1).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command valid; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- addr  in  32  byte address.
- wdata  in  32  store data (right-justified).
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse (success or error).
- err_align  out  1  valid with done; misaligned access or reserved size.
- err_timeout  out  1  valid with done; memory did not respond.
- load_data  out  32  right-justified load result, upper unused bits zero.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable, valid with mem_req.
- mem_addr  out  32  {addr[31:2],2'b00}.
- mem_be  out  4  byte enables, bit i = byte lane i (little-endian).
- mem_wdata  out  32  lane-replicated store data.
- mem_ready  in  1  memory completion; meaningful only while mem_req=1.
- mem_rdata  in  32  read word, valid when mem_ready=1 on a load.

Behaviour:
- Reset values: state IDLE; busy, done, err_align, err_timeout, mem_req and mem_we are 0; mem_addr, mem_be, mem_wdata and load_data are 0; timeout counter is 0.
- Reset mid-operation: the access is abandoned immediately, with no done pulse, and all outputs take reset values on the next edge.
- States: IDLE, REQ, FIN.
- IDLE, start=1:
  - Latch is_store, size, addr and wdata.
  - Misaligned if size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=0.
  - Misaligned: go to FIN with the align flag set. mem_req is never asserted.
  - Otherwise: go to REQ, clear the counter, drive the mem_* outputs from the latched values.
- start while busy=1 is ignored, not queued.
- REQ:
  - mem_req=1 with mem_* outputs stable for the whole state.
  - mem_ready=1: on that edge, for a load, capture the aligned mem_rdata into load_data. Go to FIN.
  - mem_ready=0 and counter==TIMEOUT_CYCLES-1: go to FIN with the timeout flag set. load_data is unchanged.
  - Otherwise: increment the counter.
  - mem_req is therefore high for at most TIMEOUT_CYCLES cycles. It deasserts in the FIN cycle.
- FIN:
  - done=1 for exactly one cycle, with err_align/err_timeout valid in the same cycle.
  - Flags clear afterwards. Next state is IDLE.
- Latency, start edge to done cycle:
  - Zero-wait memory (mem_ready in the first REQ cycle): 2 cycles.
  - Misaligned: 1 cycle.
- Byte enables:
  - byte: 1 << addr[1:0].
  - half: 0011 if addr[1]=0, 1100 if addr[1]=1.
  - word: 1111.
  - Loads drive the same mem_be pattern.
- Write data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Load alignment:
  - byte: {24'h0, mem_rdata[8*addr[1:0] +: 8]}.
  - half: {16'h0, mem_rdata[16*addr[1] +: 16]}.
  - word: mem_rdata.
- load_data holds its value until the next successful load. Stores and errors do not change it.
- mem_ready while mem_req=0 is ignored.

Test Plan:
- Reset then idle: all outputs 0, busy=0. Pulse rst=1 while in REQ: next cycle mem_req=0, busy=0, and no done pulse follows.
- Byte load, addr=0x1003, mem_rdata=0xAABBCCDD, mem_ready in the first REQ cycle:
  - mem_addr=0x1000, mem_be=1000, mem_we=0.
  - done 2 cycles after start, load_data=0x000000AA, no error flags.
- Half store, addr=0x2002, wdata=0x1234BEEF, mem_ready after 3 wait cycles:
  - mem_we=1, mem_be=1100, mem_wdata=0xBEEFBEEF.
  - mem_req high for 4 cycles, done next cycle, load_data unchanged.
- Misaligned accesses: word load at addr=0x3001, half at 0x3001, and size=11:
  - Each gives done 1 cycle after start with err_align=1.
  - mem_req stays 0 throughout.
- Timeout, TIMEOUT_CYCLES=4, mem_ready held 0:
  - mem_req high exactly 4 cycles, then done=1 with err_timeout=1.
  - A later load completes normally.
- Start asserted continuously across a busy access:
  - Only one access runs. The next start is accepted in the IDLE cycle after done.
  - The second command's mem_* values match its own inputs.
